dmem_bus_bridge: RTL

//  Sits directly downstream of the single-cycle control stage's DMEM port (daddr/dwe/dwdata/drdata).

---
 rtl/dmem_bus_bridge.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_bus_bridge.sv
// Data-memory bus bridge: turns each single-cycle CPU load/store into a
// valid/ready request and a response on a multi-cycle memory bus. The CPU is
// stalled until the access completes. A dead slave is cut off by a response
// timeout that completes the access with zero data and a sticky error flag.
module dmem_bus_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic [31:0] daddr,
  input  logic [3:0]  dwe,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        stall,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;

  // Last counter value still inside the response window.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      drdata_q, drdata_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic             access;

  // Any strobe makes the access a store, even if a load is also decoded.
  assign access = mem_rd | (|dwe);

  // Next-state, request capture, response/timeout handling and stall generation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drdata_d      = drdata_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    write_d       = write_q;
    err_d         = err_q;
    stall         = 1'b0;
    bus_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // Stall must rise in the same cycle the access appears.
        stall = access;
        if (access) begin
          addr_d  = {daddr[31:2], 2'b00};
          write_d = |dwe;
          wstrb_d = dwe;
          wdata_d = dwdata;
          state_d = REQ;
        end
      end
      REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the last window cycle beats the timeout.
        if (bus_rsp_valid) begin
          if (!write_q) begin
            drdata_d = bus_rdata;
          end
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          drdata_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Stall is low here so the CPU commits the instruction on this edge.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drdata_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drdata_q <= drdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      write_q  <= write_d;
      err_q    <= err_d;
    end
  end

  assign drdata    = drdata_q;
  assign bus_err   = err_q;
  assign bus_addr  = addr_q;
  assign bus_write = write_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;

endmodule
